v_alu_wb_packer: RTL and testbench
==================================

Name: v_alu_wb_packer

Overview:
- Downstream consumer of the lane ALU result port (fixed-latency valid/result stream, no stall capability).
- Packs per-element results (8/16/32-bit, zero-extended in 32-bit result) into 32-bit VRF write words with byte enables and word addresses.
- Buffers packed words in a small FIFO so the VRF write port may apply backpressure.
- Raises almost-full early enough to cover the ALU pipeline depth.

Parameters:
- ADDR_W, 9, VRF word-address width.
- VL_W, 12, element-count width.
- FIFO_DEPTH, 8, packed-word FIFO entries (power of two).
- AFULL_THR, 4, almost_full_o asserts when free entries <= AFULL_THR (equals ALU pipeline depth).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start_i  in  1  one-cycle pulse, new instruction; sampled only in IDLE
- sew_i  in  3  element width at start: 000=8, 001=16, 010=32; others treated as 32
- vl_i  in  VL_W  element count at start
- base_addr_i  in  ADDR_W  first destination word address at start
- res_vld_i  in  1  ALU result valid
- res_i  in  32  ALU result, valid bits in LSBs per SEW
- wr_vld_o  out  1  write request valid
- wr_rdy_i  in  1  VRF accepts write
- wr_addr_o  out  ADDR_W  write word address
- wr_data_o  out  32  packed data
- wr_be_o  out  4  byte enables
- almost_full_o  out  1  upstream must stop issuing
- busy_o  out  1  instruction in progress
- done_o  out  1  one-cycle pulse, last word accepted
- ovf_o  out  1  sticky overflow error, cleared by reset or next start

Behaviour:
- Reset: all outputs 0; FSM IDLE; FIFO empty; counters, pack register and ovf cleared.
- FSM states: IDLE, PACK, DRAIN.
  - IDLE: on start_i, latch sew, vl and base address; clear element count, lane position and ovf.
    - vl_i != 0: go to PACK.
    - vl_i == 0: pulse done_o next cycle, stay IDLE, no writes.
  - PACK: each res_vld_i places res_i at lane position pos and sets the matching BE bits.
    - SEW8: bytes, pos 0..3. SEW16: halfwords, pos 0..1. SEW32: pos 0 only.
    - Word completes when pos is the last position or the element is the vl-th. The completed word pushes {addr, data, be} the same cycle; addr then increments by 1; pos and pack register clear.
    - A partial final word carries only the filled BE bits; unfilled data bytes are 0.
    - After the vl-th element, go to DRAIN.
  - DRAIN: once the FIFO is empty (last pop accepted), pulse done_o, deassert busy_o the same cycle, go to IDLE.
- Throughput: one element per cycle in; one word per cycle out.
- Latency: the completing element appears at wr_vld_o on the next cycle (registered FIFO output, first-word-fall-through).
- Handshake: a word transfers when wr_vld_o && wr_rdy_i. wr_addr_o, wr_data_o and wr_be_o stay stable while wr_vld_o && !wr_rdy_i.
- FIFO full + push + pop in the same cycle: both happen, no loss. Full + push without pop: word dropped, ovf_o set.
- res_vld_i in IDLE/DRAIN: ignored; sets ovf_o if it occurs in DRAIN.
- start_i while busy_o: ignored.
- Address wraps modulo 2^ADDR_W.
- busy_o = state != IDLE.
- Reset mid-operation: immediate return to reset state; pending words are discarded.

Optional Feature:
- Macro WB_PACKER_MASK_EN.
- When defined, adds input mask_mode_i (1 bit, latched at start).
  - In mask mode, bit 0 of each result packs into bit position idx%32 (32 elements per word).
  - BE covers every byte holding any filled bit.
  - A word completes at 32 elements or at vl; SEW is ignored.
- When undefined, the port is absent and behaviour is as above.

Decomposition:
- Shared package:
  - SEW encoding constants.
  - FSM state enum.
  - Write-request struct {addr, data, be}.
  - ALU pipeline-depth constant (4), used as the AFULL_THR default.
- Sub-module v_wb_fifo: synchronous FWFT FIFO, parameterised width/depth, with full, empty and free-count outputs.

Test Plan:
- SEW8, vl=6, base=0x10, results 0x11..0x66, wr_rdy=1 -> writes {0x10, 0x44332211, 1111} and {0x11, 0x00006655, 0011}; done_o pulses after the second write.
- SEW16, vl=3, results 0xAAAA, 0xBBBB, 0xCCCC -> {base, 0xBBBBAAAA, 1111} and {base+1, 0x0000CCCC, 0011}.
- SEW32, vl=10, wr_rdy held 0 for 20 cycles -> almost_full_o asserts at 4 stored words (8 entries, free <= 4); with upstream stopped there, no ovf_o; after release, 10 writes in address order.
- FIFO full, wr_rdy=0, one extra completed word -> ovf_o=1; contents unchanged; next start clears ovf_o.
- vl=0 start -> done_o pulses next cycle, zero writes, busy_o stays 0. Reset asserted mid-PACK -> all outputs 0 next cycle, and a new start works.
- WB_PACKER_MASK_EN, vl=40, alternating results 1/0 -> {base, 0x55555555, 1111} and {base+1, 0x00000055, 0001}.

Source files
------------

// File: rtl/v_alu_wb_packer_pkg.sv
// Shared types for the ALU write-back packer: SEW codes, FSM states, write-request word.
package v_alu_wb_packer_pkg;
   localparam logic [2:0] SEW_8  = 3'b000;
   localparam logic [2:0] SEW_16 = 3'b001;
   localparam logic [2:0] SEW_32 = 3'b010;

   localparam int ALU_PIPE_DEPTH = 4;
   localparam int WB_ADDR_W      = 9;

   typedef enum logic [1:0] {ST_IDLE, ST_PACK, ST_DRAIN} wb_state_t;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [31:0]          data;
      logic [3:0]           be;
   } wr_req_t;

   // Reserved encodings behave as 32-bit elements.
   function automatic logic [2:0] norm_sew(input logic [2:0] s);
      return (s == SEW_8 || s == SEW_16) ? s : SEW_32;
   endfunction
endpackage

// File: rtl/v_alu_wb_packer_fifo.sv
// Synchronous first-word-fall-through FIFO; head visible the cycle after push.
// Push while full is accepted only if a pop happens the same cycle, otherwise ignored.
module v_wb_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push_i,
   input  logic [W-1:0]               push_dat_i,
   input  logic                       pop_i,
   output logic [W-1:0]               pop_dat_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     free_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_cnt;
   logic          w_push;
   logic          w_pop;

   assign full_o    = (r_cnt == CW'(DEPTH));
   assign empty_o   = (r_cnt == '0);
   assign free_o    = CW'(DEPTH) - r_cnt;
   assign pop_dat_o = r_mem[r_rd];
   assign w_pop     = pop_i && !empty_o;
   assign w_push    = push_i && (!full_o || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= push_dat_i;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end
endmodule

// File: rtl/v_alu_wb_packer.sv
// Packs ALU element results into addressed VRF words; completed word reaches wr_vld_o next cycle.
// Write port may stall; almost_full_o covers the ALU pipeline. WB_PACKER_MASK_EN adds mask_mode_i.
module v_alu_wb_packer
   import v_alu_wb_packer_pkg::*;
#(
   parameter int ADDR_W     = WB_ADDR_W,
   parameter int VL_W       = 12,
   parameter int FIFO_DEPTH = 8,
   parameter int AFULL_THR  = ALU_PIPE_DEPTH
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start_i,
   input  logic [2:0]        sew_i,
   input  logic [VL_W-1:0]   vl_i,
   input  logic [ADDR_W-1:0] base_addr_i,
`ifdef WB_PACKER_MASK_EN
   input  logic              mask_mode_i,
`endif
   input  logic              res_vld_i,
   input  logic [31:0]       res_i,
   output logic              wr_vld_o,
   input  logic              wr_rdy_i,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [31:0]       wr_data_o,
   output logic [3:0]        wr_be_o,
   output logic              almost_full_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              ovf_o
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   wb_state_t         r_state;
   logic [2:0]        r_sew;
   logic [VL_W-1:0]   r_vl;
   logic [VL_W-1:0]   r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [4:0]        r_pos;
   logic [31:0]       r_pack;
   logic [3:0]        r_be;
   logic              r_done;
   logic              r_ovf;

   logic              w_mask;
   logic [31:0]       w_data;
   logic [3:0]        w_be;
   logic              w_pos_last;
   logic              w_last_elem;
   logic              w_complete;
   logic              w_drop;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [CNT_W-1:0]  w_free;
   wr_req_t           w_push_req;
   wr_req_t           w_head;

`ifdef WB_PACKER_MASK_EN
   logic r_mask;
   assign w_mask = r_mask;
`else
   assign w_mask = 1'b0;
`endif

   // Merge the incoming element into the word under construction.
   always_comb begin
      w_data     = r_pack;
      w_be       = r_be;
      w_pos_last = 1'b0;
      if (w_mask) begin
         w_data     = r_pack | (32'(res_i[0]) << r_pos);
         w_be       = r_be | (4'b0001 << r_pos[4:3]);
         w_pos_last = (r_pos == 5'd31);
      end else begin
         case (r_sew)
            SEW_8: begin
               w_data     = r_pack | (32'(res_i[7:0]) << {r_pos[1:0], 3'b000});
               w_be       = r_be | (4'b0001 << r_pos[1:0]);
               w_pos_last = (r_pos[1:0] == 2'd3);
            end
            SEW_16: begin
               w_data     = r_pack | (32'(res_i[15:0]) << {r_pos[0], 4'b0000});
               w_be       = r_be | (4'b0011 << {r_pos[0], 1'b0});
               w_pos_last = r_pos[0];
            end
            default: begin
               w_data     = res_i;
               w_be       = 4'hF;
               w_pos_last = 1'b1;
            end
         endcase
      end
   end

   assign w_last_elem = (r_cnt + VL_W'(1) == r_vl);
   assign w_complete  = (r_state == ST_PACK) && res_vld_i && (w_pos_last || w_last_elem);
   assign w_pop       = wr_vld_o && wr_rdy_i;
   assign w_drop      = w_complete && w_full && !w_pop;
   assign w_push_req  = '{addr: r_addr, data: w_data, be: w_be};

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
         r_sew   <= SEW_8;
         r_vl    <= '0;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_pos   <= '0;
         r_pack  <= '0;
         r_be    <= '0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
`ifdef WB_PACKER_MASK_EN
         r_mask  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         if (w_drop) r_ovf <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_sew  <= norm_sew(sew_i);
                  r_vl   <= vl_i;
                  r_addr <= base_addr_i;
                  r_cnt  <= '0;
                  r_pos  <= '0;
                  r_pack <= '0;
                  r_be   <= '0;
                  r_ovf  <= 1'b0;
`ifdef WB_PACKER_MASK_EN
                  r_mask <= mask_mode_i;
`endif
                  if (vl_i != '0) r_state <= ST_PACK;
                  else            r_done  <= 1'b1;
               end
            end
            ST_PACK: begin
               if (res_vld_i) begin
                  r_cnt <= r_cnt + VL_W'(1);
                  if (w_complete) begin
                     r_addr <= r_addr + ADDR_W'(1);
                     r_pos  <= '0;
                     r_pack <= '0;
                     r_be   <= '0;
                  end else begin
                     r_pos  <= r_pos + 5'd1;
                     r_pack <= w_data;
                     r_be   <= w_be;
                  end
                  if (w_last_elem) r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (res_vld_i) r_ovf <= 1'b1;
               if (w_empty) begin
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   v_wb_fifo #(
      .W     ($bits(wr_req_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .push_i     (w_complete),
      .push_dat_i (w_push_req),
      .pop_i      (w_pop),
      .pop_dat_o  (w_head),
      .full_o     (w_full),
      .empty_o    (w_empty),
      .free_o     (w_free)
   );

   // Gate the head so stale storage never shows on the bus.
   assign wr_vld_o      = !w_empty;
   assign wr_addr_o     = wr_vld_o ? w_head.addr : '0;
   assign wr_data_o     = wr_vld_o ? w_head.data : '0;
   assign wr_be_o       = wr_vld_o ? w_head.be   : '0;
   assign almost_full_o = (w_free <= CNT_W'(AFULL_THR));
   assign busy_o        = (r_state != ST_IDLE);
   assign done_o        = r_done;
   assign ovf_o         = r_ovf;
endmodule

// File: tb/tb_v_alu_wb_packer.sv
// Randomised bench for v_alu_wb_packer against an arithmetic packing model.
module tb_v_alu_wb_packer;
   logic        clk;
   logic        rstn;
   logic        start_i;
   logic [2:0]  sew_i;
   logic [11:0] vl_i;
   logic [8:0]  base_addr_i;
`ifdef WB_PACKER_MASK_EN
   logic        mask_mode_i;
`endif
   logic        res_vld_i;
   logic [31:0] res_i;
   logic        wr_vld_o;
   logic        wr_rdy_i;
   logic [8:0]  wr_addr_o;
   logic [31:0] wr_data_o;
   logic [3:0]  wr_be_o;
   logic        almost_full_o;
   logic        busy_o;
   logic        done_o;
   logic        ovf_o;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
   logic [31:0] res_a[$];
   logic [44:0] obs_q[$];
   logic [44:0] exp_q[$];
   logic        prev_stall = 1'b0;
   logic [44:0] prev_word  = '0;

   v_alu_wb_packer dut (
      .clk           (clk),
      .rstn          (rstn),
      .start_i       (start_i),
      .sew_i         (sew_i),
      .vl_i          (vl_i),
      .base_addr_i   (base_addr_i),
`ifdef WB_PACKER_MASK_EN
      .mask_mode_i   (mask_mode_i),
`endif
      .res_vld_i     (res_vld_i),
      .res_i         (res_i),
      .wr_vld_o      (wr_vld_o),
      .wr_rdy_i      (wr_rdy_i),
      .wr_addr_o     (wr_addr_o),
      .wr_data_o     (wr_data_o),
      .wr_be_o       (wr_be_o),
      .almost_full_o (almost_full_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .ovf_o         (ovf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      #2;
      wr_rdy_i = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   // Write-port monitor: record transfers, enforce stability while stalled.
   always @(negedge clk) begin
      if (rstn) begin
         if (prev_stall) begin
            chk("hold_vld", wr_vld_o, 1);
            chk("hold_word", {wr_addr_o, wr_data_o, wr_be_o}, prev_word);
         end
         if (wr_vld_o && wr_rdy_i) obs_q.push_back({wr_addr_o, wr_data_o, wr_be_o});
         prev_stall = wr_vld_o && !wr_rdy_i;
         prev_word  = {wr_addr_o, wr_data_o, wr_be_o};
         if (done_o) done_cnt++;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Expected words from the packing rules: element i goes to word i/epw, slot i%epw.
   function automatic void build_exp(input int sew, input int n, input int base, input bit mask);
      longint d[64];
      int     b[64];
      int     eb, epw, nw;
      exp_q.delete();
      eb  = (sew == 0) ? 1 : (sew == 1) ? 2 : 4;
      epw = mask ? 32 : 4 / eb;
      nw  = (n + epw - 1) / epw;
      for (int w = 0; w < 64; w++) begin
         d[w] = 0;
         b[w] = 0;
      end
      for (int i = 0; i < n; i++) begin
         int wi, si;
         wi = i / epw;
         si = i % epw;
         if (mask) begin
            d[wi] |= longint'(res_a[i][0]) << si;
            b[wi] |= 1 << (si / 8);
         end else begin
            d[wi] |= (longint'(res_a[i]) & ((64'd1 << (8 * eb)) - 1)) << (8 * eb * si);
            b[wi] |= ((1 << eb) - 1) << (eb * si);
         end
      end
      for (int w = 0; w < nw; w++)
         exp_q.push_back({9'((base + w) % 512), d[w][31:0], b[w][3:0]});
   endfunction

   task automatic start_op(input logic [2:0] sew, input int vl, input int base);
      obs_q.delete();
      sew_i       = sew;
      vl_i        = 12'(vl);
      base_addr_i = 9'(base);
      start_i     = 1'b1;
      step;
      start_i     = 1'b0;
   endtask

   task automatic drive_elem(input int i, input bit junk_start);
      res_vld_i = 1'b1;
      res_i     = res_a[i];
      start_i   = junk_start;
      vl_i      = '0;
      step;
      res_vld_i = 1'b0;
      start_i   = 1'b0;
   endtask

   task automatic feed(input int lo, input int hi, input bit honor, input bit gaps, input bit junk);
      for (int i = lo; i < hi; i++) begin
         int b = 0;
         while (honor && almost_full_o && b < 300) begin
            step;
            b++;
         end
         if (b >= 300) chk("afull_timeout", 1, 0);
         if (gaps && $urandom_range(0, 3) == 0) step;
         drive_elem(i, junk && i == 1);
      end
   endtask

   task automatic finish_op(input string tag, input int d0, input logic exp_ovf);
      int b = 0;
      while (done_cnt == d0 && b < 2000) begin
         step;
         b++;
      end
      chk({tag, "_done_timeout"}, b < 2000, 1);
      chk({tag, "_n_words"}, obs_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
         chk({tag, "_word"}, obs_q[k], exp_q[k]);
      step;
      step;
      chk({tag, "_done_pulses"}, done_cnt - d0, 1);
      chk({tag, "_busy_after"}, busy_o, 0);
      chk({tag, "_ovf"}, ovf_o, exp_ovf);
   endtask

   task automatic rand_op;
      int sew, eff, vl, base, d0;
      sew  = $urandom_range(0, 7);
      eff  = (sew == 0) ? 0 : (sew == 1) ? 1 : 2;
      vl   = $urandom_range(1, 40);
      base = ($urandom_range(0, 1) == 1) ? $urandom_range(504, 511) : $urandom_range(0, 511);
      rdy_mode = $urandom_range(0, 1);
      res_a.delete();
      for (int i = 0; i < vl; i++) begin
         logic [31:0] r;
         r = $urandom;
         if (eff == 0) r &= 32'hFF;
         if (eff == 1) r &= 32'hFFFF;
         res_a.push_back(r);
      end
      d0 = done_cnt;
      start_op(3'(sew), vl, base);
      feed(0, vl, 1, 1, 1);
      build_exp(eff, vl, base, 0);
      finish_op("rand", d0, 0);
   endtask

   initial begin
      int d0, i;
      rstn = 1'b0; start_i = 1'b0; sew_i = '0; vl_i = '0; base_addr_i = '0;
      res_vld_i = 1'b0; res_i = '0;
`ifdef WB_PACKER_MASK_EN
      mask_mode_i = 1'b0;
`endif
      repeat (3) step;
      chk("reset_outs", {wr_vld_o, wr_addr_o, wr_data_o, wr_be_o, almost_full_o, busy_o, done_o, ovf_o}, '0);
      rstn = 1'b1;
      step;

      // SEW8, six bytes into two words
      res_a = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
      exp_q = '{{9'h010, 32'h44332211, 4'b1111}, {9'h011, 32'h00006655, 4'b0011}};
      d0 = done_cnt;
      start_op(3'b000, 6, 'h10);
      chk("t1_busy", busy_o, 1);
      feed(0, 6, 1, 0, 0);
      finish_op("t1", d0, 0);

      // SEW16 with partial tail
      res_a = '{32'hAAAA, 32'hBBBB, 32'hCCCC};
      exp_q = '{{9'h020, 32'hBBBBAAAA, 4'b1111}, {9'h021, 32'h0000CCCC, 4'b0011}};
      d0 = done_cnt;
      start_op(3'b001, 3, 'h20);
      feed(0, 3, 1, 0, 0);
      finish_op("t2", d0, 0);

      // SEW32 with stalled write port; upstream obeys almost_full; address wraps
      rdy_mode = 2;
      res_a.delete();
      for (int k = 0; k < 10; k++) res_a.push_back($urandom);
      d0 = done_cnt;
      start_op(3'b010, 10, 'h1FC);
      i = 0;
      while (!almost_full_o && i < 10) begin
         drive_elem(i, 0);
         i++;
      end
      chk("t3_afull_at", i, 4);
      repeat (16) step;
      chk("t3_afull_held", almost_full_o, 1);
      chk("t3_no_ovf", ovf_o, 0);
      chk("t3_no_writes", obs_q.size(), 0);
      rdy_mode = 0;
      feed(i, 10, 1, 0, 0);
      build_exp(2, 10, 'h1FC, 0);
      finish_op("t3", d0, 0);

      // Overflow: nine words into an eight-entry FIFO while stalled
      rdy_mode = 2;
      res_a.delete();
      for (int k = 0; k < 9; k++) res_a.push_back($urandom);
      d0 = done_cnt;
      start_op(3'b010, 9, 'h40);
      feed(0, 9, 0, 0, 0);
      chk("t4_ovf_set", ovf_o, 1);
      chk("t4_held", obs_q.size(), 0);
      build_exp(2, 8, 'h40, 0);
      rdy_mode = 0;
      finish_op("t4", d0, 1);

      // vl=0 start: done next cycle, no writes, clears ovf
      start_op(3'b000, 0, 'h55);
      chk("t5_done", done_o, 1);
      chk("t5_busy", busy_o, 0);
      chk("t5_ovf_clr", ovf_o, 0);
      step;
      chk("t5_done_off", done_o, 0);
      chk("t5_no_writes", obs_q.size() + 32'(wr_vld_o), 0);

      // Reset in the middle of PACK
      rdy_mode = 2;
      res_a.delete();
      for (int k = 0; k < 20; k++) res_a.push_back($urandom & 32'hFF);
      start_op(3'b000, 20, 'h80);
      feed(0, 5, 1, 0, 0);
      chk("t6_pending", wr_vld_o, 1);
      rstn = 1'b0;
      step;
      chk("t6_rst_outs", {wr_vld_o, wr_addr_o, wr_data_o, wr_be_o, almost_full_o, busy_o, done_o, ovf_o}, '0);
      rstn = 1'b1;
      rdy_mode = 0;
      step;
      chk("t6_discarded", wr_vld_o, 0);

`ifdef WB_PACKER_MASK_EN
      // Mask mode: bit 0 of each result, 32 per word
      res_a.delete();
      for (int k = 0; k < 40; k++) res_a.push_back((k % 2 == 0) ? 32'h1 : 32'h0);
      exp_q = '{{9'h030, 32'h55555555, 4'b1111}, {9'h031, 32'h00000055, 4'b0001}};
      mask_mode_i = 1'b1;
      d0 = done_cnt;
      start_op(3'b000, 40, 'h30);
      mask_mode_i = 1'b0;
      feed(0, 40, 1, 0, 0);
      finish_op("mask", d0, 0);
`endif

      for (int n = 0; n < 30; n++) rand_op();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
